// File: rtl/unos_broja.sv
// Keyboard number entry: filters PS/2 prefixes, collects up to two digits, hands the
// converted value to the consumer over valid/ready. Optional idle timeout: UNOS_TIMEOUT_EN.
module unos_broja #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] key_code_1,
    output logic [7:0] key_code_2,
    input  logic [7:0] dekadski_broj,
    output logic [7:0] broj,
    output logic       broj_valid,
    input  logic       broj_ready,
    output logic [1:0] digit_count
);
    localparam logic [7:0] K_ZERO  = 8'h45;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_BKSP  = 8'h66;
    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;

    typedef enum logic [1:0] {PRAZNO, JEDAN, DVA, IZLAZ} state_t;

    function automatic logic is_digit(input logic [7:0] c);
        case (c)
            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_digit = 1'b1;
            default:                           is_digit = 1'b0;
        endcase
    endfunction

    state_t state, nxt;
    logic   brk;
    logic   evt, evt_digit, evt_enter, evt_bksp;
    logic   ld_digit, ld_bksp, ld_cap, ld_ack, ld_clr;
    logic   timeout;

    // A code is a key event only if it is neither a prefix nor the code after a break.
    assign evt       = scan_valid && !brk && scan_code != K_BRK && scan_code != K_EXT;
    assign evt_digit = evt && is_digit(scan_code);
    assign evt_enter = evt && scan_code == K_ENTER;
    assign evt_bksp  = evt && scan_code == K_BKSP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == K_BRK)      brk <= 1'b1;
            else if (scan_code != K_EXT) brk <= 1'b0;
        end
    end

`ifdef UNOS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (scan_valid || !(state == JEDAN || state == DVA))
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end

    assign timeout = (state == JEDAN || state == DVA) && !scan_valid &&
                     idle_cnt == TW'(TIMEOUT_CYCLES);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PRAZNO;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            PRAZNO: if (evt_digit) nxt = JEDAN;
            JEDAN: begin
                if (timeout)        nxt = PRAZNO;
                else if (evt_digit) nxt = DVA;
                else if (evt_bksp)  nxt = PRAZNO;
                else if (evt_enter) nxt = IZLAZ;
            end
            DVA: begin
                if (timeout)        nxt = PRAZNO;
                else if (evt_bksp)  nxt = JEDAN;
                else if (evt_enter) nxt = IZLAZ;
            end
            IZLAZ: if (broj_ready) nxt = PRAZNO;
            default: nxt = PRAZNO;
        endcase
    end

    always_comb begin
        ld_digit = evt_digit && (state == PRAZNO || state == JEDAN);
        ld_bksp  = evt_bksp  && (state == JEDAN || state == DVA);
        ld_cap   = evt_enter && (state == JEDAN || state == DVA);
        ld_ack   = state == IZLAZ && broj_ready;
        ld_clr   = timeout || ld_ack;
    end

    // Unused stages hold the '0' code so the converter reads a leading zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_1  <= K_ZERO;
            key_code_2  <= K_ZERO;
            digit_count <= 2'd0;
            broj        <= 8'h00;
            broj_valid  <= 1'b0;
        end else begin
            if (ld_clr) begin
                key_code_1  <= K_ZERO;
                key_code_2  <= K_ZERO;
                digit_count <= 2'd0;
            end else if (ld_digit) begin
                key_code_1  <= key_code_2;
                key_code_2  <= scan_code;
                digit_count <= digit_count + 2'd1;
            end else if (ld_bksp) begin
                key_code_2  <= key_code_1;
                key_code_1  <= K_ZERO;
                digit_count <= digit_count - 2'd1;
            end
            if (ld_cap) begin
                broj       <= dekadski_broj;
                broj_valid <= 1'b1;
            end else if (ld_ack) begin
                broj_valid <= 1'b0;
            end
        end
    end
endmodule
